// File: rtl/gemm_row_sequencer.sv
// gemm_row_sequencer: fetches one input vector, BLOCK weight rows and an accumulator vector,
// steps a combinational dot-product row once per output element, then writes the results back.
module gemm_row_sequencer #(
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int BLOCK     = 16,
    parameter int INP_AW    = 11,
    parameter int WGT_AW    = 10,
    parameter int ACC_AW    = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [INP_AW-1:0]            cmd_inp_idx,
    input  logic [WGT_AW-1:0]            cmd_wgt_idx,
    input  logic [ACC_AW-1:0]            cmd_acc_idx,
    input  logic                         cmd_reset_acc,
    output logic                         inp_rd_en,
    output logic [INP_AW-1:0]            inp_rd_addr,
    input  logic [BLOCK*INP_WIDTH-1:0]   inp_rd_data,
    output logic                         wgt_rd_en,
    output logic [WGT_AW-1:0]            wgt_rd_addr,
    input  logic [BLOCK*WGT_WIDTH-1:0]   wgt_rd_data,
    output logic                         acc_rd_en,
    output logic [ACC_AW-1:0]            acc_rd_addr,
    input  logic [BLOCK*ACC_WIDTH-1:0]   acc_rd_data,
    output logic [BLOCK*INP_WIDTH-1:0]   row_i,
    output logic [BLOCK*WGT_WIDTH-1:0]   row_w,
    output logic [ACC_WIDTH-1:0]         row_a,
    input  logic [ACC_WIDTH-1:0]         row_o,
    output logic                         acc_wr_en,
    output logic [ACC_AW-1:0]            acc_wr_addr,
    output logic [BLOCK*ACC_WIDTH-1:0]   acc_wr_data,
    output logic                         done
);
    localparam int KW = $clog2(BLOCK);

    typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, WRITE} state_t;

    state_t                       state;
    logic [KW-1:0]                k;
    logic [WGT_AW-1:0]            wgt_idx;
    logic [ACC_AW-1:0]            acc_idx;
    logic                         reset_acc;
    logic [BLOCK*INP_WIDTH-1:0]   inp_q;
    logic [BLOCK*INP_WIDTH-1:0]   inp_cur;
    logic [BLOCK*ACC_WIDTH-1:0]   acc_q;
    logic [BLOCK*ACC_WIDTH-1:0]   acc_cur;
    logic [BLOCK*ACC_WIDTH-1:0]   res;

    // Row operands: live read data on step 0, registered copies afterwards, zero outside COMPUTE
    always_comb begin
        inp_cur     = (k == '0) ? inp_rd_data : inp_q;
        acc_cur     = (k == '0) ? (reset_acc ? '0 : acc_rd_data) : acc_q;
        row_i       = (state == COMPUTE) ? inp_cur : '0;
        row_w       = (state == COMPUTE) ? wgt_rd_data : '0;
        row_a       = (state == COMPUTE) ? acc_cur[k*ACC_WIDTH +: ACC_WIDTH] : '0;
        acc_wr_data = acc_wr_en ? res : '0;
    end

    // Sequencer: command latch, read issue one cycle ahead of use, result capture and write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            wgt_idx     <= '0;
            acc_idx     <= '0;
            reset_acc   <= 1'b0;
            inp_q       <= '0;
            acc_q       <= '0;
            res         <= '0;
            cmd_ready   <= 1'b1;
            inp_rd_en   <= 1'b0;
            inp_rd_addr <= '0;
            wgt_rd_en   <= 1'b0;
            wgt_rd_addr <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_addr <= '0;
            acc_wr_en   <= 1'b0;
            acc_wr_addr <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    state       <= FETCH;
                    cmd_ready   <= 1'b0;
                    wgt_idx     <= cmd_wgt_idx;
                    acc_idx     <= cmd_acc_idx;
                    reset_acc   <= cmd_reset_acc;
                    inp_rd_en   <= 1'b1;
                    inp_rd_addr <= cmd_inp_idx;
                    wgt_rd_en   <= 1'b1;
                    wgt_rd_addr <= cmd_wgt_idx;
                    acc_rd_en   <= !cmd_reset_acc;
                    acc_rd_addr <= cmd_acc_idx;
                end
                FETCH: begin
                    state       <= COMPUTE;
                    k           <= '0;
                    inp_rd_en   <= 1'b0;
                    acc_rd_en   <= 1'b0;
                    wgt_rd_en   <= 1'b1;
                    wgt_rd_addr <= wgt_idx + WGT_AW'(1);
                end
                COMPUTE: begin
                    res[k*ACC_WIDTH +: ACC_WIDTH] <= row_o;
                    if (k == '0) begin
                        inp_q <= inp_rd_data;
                        acc_q <= acc_cur;
                    end
                    k           <= k + 1'b1;
                    wgt_rd_en   <= k < KW'(BLOCK-2);
                    wgt_rd_addr <= wgt_idx + WGT_AW'(k) + WGT_AW'(2);
                    if (k == KW'(BLOCK-1)) begin
                        state       <= WRITE;
                        acc_wr_en   <= 1'b1;
                        acc_wr_addr <= acc_idx;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc_wr_en <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_row_sequencer.sv
// tb_gemm_row_sequencer: directed vectors against scratchpad and dot-product row models
module tb_gemm_row_sequencer;
    localparam int B = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid, cmd_ready, cmd_reset_acc;
    logic [10:0]  cmd_inp_idx, cmd_acc_idx;
    logic [9:0]   cmd_wgt_idx;
    logic         inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, done;
    logic [10:0]  inp_rd_addr, acc_rd_addr, acc_wr_addr;
    logic [9:0]   wgt_rd_addr;
    logic [127:0] inp_rd_data, wgt_rd_data, row_i, row_w;
    logic [511:0] acc_rd_data, acc_wr_data;
    logic [31:0]  row_a, row_o;

    logic [127:0] inp_mem [0:2047];
    logic [127:0] wgt_mem [0:1023];
    logic [511:0] acc_mem [0:2047];

    int total = 0, bad = 0;
    int wr_cnt = 0, done_cnt = 0, cyc = 0, acc_at = 0;

    gemm_row_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_inp_idx(cmd_inp_idx), .cmd_wgt_idx(cmd_wgt_idx),
        .cmd_acc_idx(cmd_acc_idx), .cmd_reset_acc(cmd_reset_acc),
        .inp_rd_en(inp_rd_en), .inp_rd_addr(inp_rd_addr), .inp_rd_data(inp_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .row_i(row_i), .row_w(row_w), .row_a(row_a), .row_o(row_o),
        .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
        .done(done)
    );

    function automatic logic [511:0] rnd();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scratchpads: one-cycle read latency, junk on the data bus when no read was issued
    always @(posedge clk) begin
        inp_rd_data <= inp_rd_en ? inp_mem[inp_rd_addr] : 128'(rnd());
        wgt_rd_data <= wgt_rd_en ? wgt_mem[wgt_rd_addr] : 128'(rnd());
        acc_rd_data <= acc_rd_en ? acc_mem[acc_rd_addr] : rnd();
    end

    // Dot-product row: unsigned MACs onto the accumulator element, wrapping at 32 bits
    always_comb begin
        row_o = row_a;
        for (int j = 0; j < B; j++) row_o = row_o + 32'(row_i[j*8 +: 8]) * 32'(row_w[j*8 +: 8]);
    end

    // Event counters for write-back and completion pulses
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [10:0] inp;
        logic [9:0]  wgt;
        logic [10:0] acc;
        logic        rz;
        int          mul;
        int          add;
        int          sk;
        logic [31:0] sv;
    } rec_t;

    rec_t tbl [4];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic rnd_cmd();
        cmd_inp_idx   = 11'($urandom);
        cmd_wgt_idx   = 10'($urandom);
        cmd_acc_idx   = 11'($urandom);
        cmd_reset_acc = 1'($urandom);
    endtask

    // Issues one command and checks every cycle from acceptance to write-back
    task automatic run_cmd(input rec_t r, input bit hold, input rec_t nxt);
        logic [9:0]  ea;
        logic [31:0] ee;
        int n;
        cmd_inp_idx = r.inp; cmd_wgt_idx = r.wgt; cmd_acc_idx = r.acc; cmd_reset_acc = r.rz;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 512'(cmd_ready), 512'(1));
        @(posedge clk);
        for (int c = 1; c <= B + 2; c++) begin
            @(negedge clk);
            if (c == 1) acc_at = cyc;
            chk($sformatf("ctl_c%0d", c), {cmd_ready, inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, done},
                {1'b0, c == 1, c <= B, c == 1 && !r.rz, c == B + 2, c == B + 2});
            if (c <= B) begin
                ea = r.wgt + 10'(c - 1);
                chk($sformatf("wgt_addr_c%0d", c), wgt_rd_addr, ea);
            end
            if (c == 1) begin
                chk("inp_addr", inp_rd_addr, r.inp);
                if (!r.rz) chk("acc_rd_addr", acc_rd_addr, r.acc);
            end
            if (c == 1 || c == B + 2) chk($sformatf("row_zero_c%0d", c), {row_i, row_w, row_a}, '0);
            if (c == B + 2) begin
                chk("wr_addr", acc_wr_addr, r.acc);
                for (int k = 0; k < B; k++) begin
                    ee = (k == r.sk) ? r.sv : 32'(r.mul * k + r.add);
                    chk($sformatf("elem%0d", k), acc_wr_data[k*32 +: 32], ee);
                end
            end
            if (hold && c == B + 2) begin
                cmd_inp_idx = nxt.inp; cmd_wgt_idx = nxt.wgt; cmd_acc_idx = nxt.acc; cmd_reset_acc = nxt.rz;
            end else rnd_cmd();
            cmd_valid = hold;
        end
    endtask

    initial begin
        int a0, w0, d0;
        for (int i = 0; i < 2048; i++) begin
            inp_mem[i] = '0;
            acc_mem[i] = '0;
        end
        for (int i = 0; i < 1024; i++) wgt_mem[i] = '0;
        inp_mem[5] = {16{8'h01}};
        inp_mem[9] = {16{8'h01}};
        for (int k = 0; k < B; k++) begin
            wgt_mem[32 + k]          = {16{8'(k)}};
            wgt_mem[10'(1016 + k)]   = {16{8'(k)}};
            wgt_mem[64 + k]          = {16{8'h01}};
            acc_mem[7][k*32 +: 32]   = 32'(100 * k);
        end
        acc_mem[3][3*32 +: 32] = 32'h7FFF_FFFF;

        tbl[0] = '{inp: 5, wgt: 32,   acc: 7, rz: 1'b0, mul: 116, add: 0,  sk: 31, sv: 0};
        tbl[1] = '{inp: 5, wgt: 32,   acc: 7, rz: 1'b1, mul: 16,  add: 0,  sk: 31, sv: 0};
        tbl[2] = '{inp: 9, wgt: 64,   acc: 3, rz: 1'b0, mul: 0,   add: 16, sk: 3,  sv: 32'h8000_000F};
        tbl[3] = '{inp: 5, wgt: 1016, acc: 7, rz: 1'b1, mul: 16,  add: 0,  sk: 31, sv: 0};

        cmd_valid = 1'($urandom);
        rnd_cmd();
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cmd_ready, inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr, acc_rd_en, acc_rd_addr,
                        acc_wr_en, acc_wr_addr, done}, {1'b1, 48'd0});
        chk("rst_rows", {row_i, row_w, row_a}, '0);
        chk("rst_wdata", acc_wr_data, '0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("idle_%0d", i), {cmd_ready, inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, done}, 6'b100000);
        end

        for (int i = 0; i < 4; i++) run_cmd(tbl[i], 1'b0, tbl[i]);

        run_cmd(tbl[0], 1'b1, tbl[2]);
        a0 = acc_at;
        run_cmd(tbl[2], 1'b0, tbl[2]);
        chk("b2b_spacing", 512'(acc_at - a0), 512'(19));

        cmd_inp_idx = tbl[0].inp; cmd_wgt_idx = tbl[0].wgt; cmd_acc_idx = tbl[0].acc; cmd_reset_acc = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", 512'(cmd_ready), 512'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        w0 = wr_cnt;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ctl", {cmd_ready, inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, done}, 6'b100000);
        chk("abort_rst_rows", {row_i, row_w, row_a}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_wr", 512'(wr_cnt - w0), '0);
        chk("abort_no_done", 512'(done_cnt - d0), '0);
        run_cmd(tbl[0], 1'b0, tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
